// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares one SDRAM controller Avalon-MM slave port between
// two masters (m0 = NIOS data path, m1 = hardware requester). Round-robin
// arbitration, one command per grant. A small ID FIFO remembers which master
// issued each outstanding read so readdatavalid can be routed back.
//
// Build option: define SDRAM_ARB_FIXED_PRIO_EN to make m0 win every tie
// (m1 can starve). Without it, ties alternate using last_gnt.
//
// state | meaning
// ------+--------------------------------------------------------------
// ARB   | no grant; pick a requester, masters stalled
// GNT   | granted master's command driven to the controller until accepted
module sdram_port_arbiter #(
   parameter int ADDR_W  = 24,
   parameter int DATA_W  = 8,
   parameter int MAX_OUT = 4
) (
   input  logic              clk_clk,
   input  logic              reset_reset,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [DATA_W-1:0] m0_writedata,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [DATA_W-1:0] m1_writedata,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,
   output logic [ADDR_W-1:0] s_address,
   output logic              s_read,
   output logic              s_write,
   output logic [DATA_W-1:0] s_writedata,
   input  logic              s_waitrequest,
   input  logic [DATA_W-1:0] s_readdata,
   input  logic              s_readdatavalid,
   output logic              err_orphan
);

   localparam int PTR_W = $clog2(MAX_OUT);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic {ST_ARB, ST_GNT} state_t;

   state_t               state_q, state_d;
   logic                 gnt_q, gnt_d;
   logic                 last_gnt_q, last_gnt_d;
   logic [MAX_OUT-1:0]   id_mem_q, id_mem_d;
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 err_orphan_q, err_orphan_d;

   logic req0, req1;
   logic sel_read, sel_write;
   logic fifo_full, fifo_empty, fifo_head;
   logic push, pop;
   logic s_read_c, s_write_c;
   logic wait0_c, wait1_c;
   logic gnt_wait;

   assign req0       = m0_read | m0_write;
   assign req1       = m1_read | m1_write;
   assign sel_read   = gnt_q ? m1_read  : m0_read;
   assign sel_write  = gnt_q ? m1_write : m0_write;
   assign fifo_full  = (cnt_q == CNT_W'(MAX_OUT));
   assign fifo_empty = (cnt_q == '0);
   assign fifo_head  = id_mem_q[rd_ptr_q];

   // A read is only pushed once the controller actually takes it.
   assign push = s_read_c & ~s_waitrequest;
   assign pop  = s_readdatavalid & ~fifo_empty;

   assign s_address   = gnt_q ? m1_address   : m0_address;
   assign s_writedata = gnt_q ? m1_writedata : m0_writedata;
   assign s_read      = s_read_c;
   assign s_write     = s_write_c;

   assign m0_waitrequest   = wait0_c;
   assign m1_waitrequest   = wait1_c;
   assign m0_readdata      = s_readdata;
   assign m1_readdata      = s_readdata;
   assign m0_readdatavalid = pop & ~fifo_head;
   assign m1_readdatavalid = pop &  fifo_head;
   assign err_orphan       = err_orphan_q;

   // Arbitration FSM: next state, grant choice and command mux qualifiers.
   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      last_gnt_d = last_gnt_q;
      s_read_c   = 1'b0;
      s_write_c  = 1'b0;
      wait0_c    = 1'b1;
      wait1_c    = 1'b1;
      gnt_wait   = 1'b1;
      case (state_q)
         ST_ARB: begin
            if (req0 && req1) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
               gnt_d = 1'b0;
`else
               gnt_d = ~last_gnt_q;
`endif
               state_d = ST_GNT;
            end else if (req0) begin
               gnt_d   = 1'b0;
               state_d = ST_GNT;
            end else if (req1) begin
               gnt_d   = 1'b1;
               state_d = ST_GNT;
            end
         end
         ST_GNT: begin
            // A read with no free ID slot is held off; writes never are.
            s_read_c  = sel_read & ~fifo_full;
            s_write_c = sel_write;
            gnt_wait  = (sel_read & fifo_full) | s_waitrequest;
            if (gnt_q) wait1_c = gnt_wait;
            else       wait0_c = gnt_wait;
            if ((s_read_c | s_write_c) && !s_waitrequest) begin
               last_gnt_d = gnt_q;
               state_d    = ST_ARB;
            end else if (!(sel_read | sel_write)) begin
               state_d = ST_ARB;
            end
         end
         default: state_d = ST_ARB;
      endcase
   end

   // Read-return ID FIFO and sticky orphan flag next-state.
   always_comb begin
      id_mem_d     = id_mem_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      cnt_d        = cnt_q;
      err_orphan_d = err_orphan_q | (s_readdatavalid & fifo_empty);
      if (push) begin
         id_mem_d[wr_ptr_q] = gnt_q;
         wr_ptr_d           = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
      else if (!push && pop) cnt_d = cnt_q - CNT_W'(1);
   end

   // State registers; reset discards all outstanding read IDs.
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         state_q      <= ST_ARB;
         gnt_q        <= 1'b0;
         last_gnt_q   <= 1'b1;
         id_mem_q     <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         cnt_q        <= '0;
         err_orphan_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         gnt_q        <= gnt_d;
         last_gnt_q   <= last_gnt_d;
         id_mem_q     <= id_mem_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         cnt_q        <= cnt_d;
         err_orphan_q <= err_orphan_d;
      end
   end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed testbench for sdram_port_arbiter with a read-ID scoreboard.
module tb_sdram_port_arbiter;

`ifdef SDRAM_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [23:0] m0_address, m1_address, s_address;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic [7:0]  m0_writedata, m1_writedata, s_writedata;
   logic        m0_waitrequest, m1_waitrequest;
   logic [7:0]  m0_readdata, m1_readdata, s_readdata;
   logic        m0_readdatavalid, m1_readdatavalid;
   logic        s_read, s_write, s_waitrequest, s_readdatavalid;
   logic        err_orphan;

   int checks = 0;
   int errors = 0;
   int exp_q[$];
   bit exp_last = 1'b1;

   always #5 clk = ~clk;

   sdram_port_arbiter #(.ADDR_W(24), .DATA_W(8), .MAX_OUT(4)) dut (
      .clk_clk(clk), .reset_reset(rst),
      .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
      .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
      .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
      .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
      .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
      .s_address(s_address), .s_read(s_read), .s_write(s_write),
      .s_writedata(s_writedata), .s_waitrequest(s_waitrequest),
      .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
      .err_orphan(err_orphan)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_m(input int m, input bit rd, input bit wr,
                          input logic [23:0] a, input logic [7:0] d);
      if (m == 0) begin
         m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d;
      end else begin
         m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d;
      end
   endtask

   // One command from master m; waits (bounded) for its grant, checks the
   // controller side, records read IDs, then drops the request after accept.
   task automatic issue(input int m, input bit rd, input logic [23:0] a, input logic [7:0] d);
      bit got = 1'b0;
      @(negedge clk);
      drive_m(m, rd, !rd, a, d);
      for (int n = 0; n < 20; n++) begin
         #1;
         if (((m == 0) ? m0_waitrequest : m1_waitrequest) == 1'b0) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("issue_grant", got, 1);
      if (got) begin
         chk("issue_addr", s_address, a);
         chk("issue_rd", s_read, rd);
         chk("issue_wr", s_write, !rd);
         if (!rd) chk("issue_wdata", s_writedata, d);
         if (rd) exp_q.push_back(m);
         exp_last = m[0];
      end
      @(posedge clk);
      #1 drive_m(m, 1'b0, 1'b0, a, d);
   endtask

   // Return one read beat; the scoreboard head says who must see it.
   task automatic ret(input logic [7:0] d);
      int id;
      @(negedge clk);
      s_readdatavalid = 1'b1;
      s_readdata      = d;
      #1;
      id = (exp_q.size() == 0) ? -1 : exp_q.pop_front();
      chk("rdv_m0", m0_readdatavalid, id == 0);
      chk("rdv_m1", m1_readdatavalid, id == 1);
      if (id >= 0) chk("rdata", (id == 0) ? m0_readdata : m1_readdata, d);
      @(posedge clk);
      #1 s_readdatavalid = 1'b0;
      if (id < 0) chk("orphan_set", err_orphan, 1);
   endtask

   initial begin
      int grants;
      int cyc;
      bit g;
      rst = 1'b1;
      drive_m(0, 1'b0, 1'b0, 24'h0, 8'h0);
      drive_m(1, 1'b0, 1'b0, 24'h0, 8'h0);
      s_waitrequest = 1'b0; s_readdatavalid = 1'b0; s_readdata = 8'h00;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_wait0", m0_waitrequest, 1);
      chk("rst_wait1", m1_waitrequest, 1);
      chk("rst_sread", s_read, 0);
      chk("rst_swrite", s_write, 0);
      chk("rst_rdv", {m0_readdatavalid, m1_readdatavalid}, 0);
      chk("rst_orphan", err_orphan, 0);
      @(negedge clk) rst = 1'b0;

      // Test 1: lone m0 read, 2nd-cycle issue, return routed to m0
      @(negedge clk);
      drive_m(0, 1'b1, 1'b0, 24'h000010, 8'h00);
      #1;
      chk("t1_c1_sread", s_read, 0);
      chk("t1_c1_wait0", m0_waitrequest, 1);
      @(negedge clk);
      #1;
      chk("t1_c2_sread", s_read, 1);
      chk("t1_c2_wait0", m0_waitrequest, 0);
      chk("t1_c2_addr", s_address, 24'h000010);
      exp_q.push_back(0);
      exp_last = 1'b0;
      @(posedge clk);
      #1 drive_m(0, 1'b0, 1'b0, 24'h0, 8'h0);
      ret(8'hA5);

      // Test 2: both masters writing continuously -> alternating grants
      @(negedge clk);
      drive_m(0, 1'b0, 1'b1, 24'h000100, 8'h11);
      drive_m(1, 1'b0, 1'b1, 24'h000200, 8'h22);
      grants = 0;
      cyc = 0;
      while (grants < 4 && cyc < 20) begin
         @(negedge clk);
         #1;
         cyc++;
         if (s_write && !s_waitrequest) begin
            g = FIXED ? 1'b0 : ~exp_last;
            chk("t2_grant", m1_waitrequest ? 0 : 1, g);
            chk("t2_other_wait", g ? m0_waitrequest : m1_waitrequest, 1);
            chk("t2_wdata", s_writedata, g ? 8'h22 : 8'h11);
            exp_last = g;
            grants++;
         end
      end
      chk("t2_grant_count", grants, 4);
      @(posedge clk);
      #1;
      drive_m(0, 1'b0, 1'b0, 24'h0, 8'h0);
      drive_m(1, 1'b0, 1'b0, 24'h0, 8'h0);

      // Test 3: m1 fills the ID FIFO; write still passes, 5th read held
      for (int i = 0; i < 4; i++) issue(1, 1'b1, 24'h000300 + 24'(i), 8'h00);
      issue(0, 1'b0, 24'h000350, 8'h5A);
      @(negedge clk);
      drive_m(1, 1'b1, 1'b0, 24'h000390, 8'h00);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         chk("t3_held_wait1", m1_waitrequest, 1);
         chk("t3_held_sread", s_read, 0);
      end
      // One return frees a slot; read still blocked in the pop cycle.
      @(negedge clk);
      s_readdatavalid = 1'b1; s_readdata = 8'h31;
      #1;
      chk("t3_pop_sread", s_read, 0);
      chk("t3_pop_rdv1", m1_readdatavalid, exp_q.pop_front() == 1);
      @(posedge clk);
      #1 s_readdatavalid = 1'b0;
      @(negedge clk);
      #1;
      chk("t3_refill_sread", s_read, 1);
      chk("t3_refill_wait1", m1_waitrequest, 0);
      chk("t3_refill_addr", s_address, 24'h000390);
      exp_q.push_back(1);
      exp_last = 1'b1;
      @(posedge clk);
      #1 drive_m(1, 1'b0, 1'b0, 24'h0, 8'h0);
      // FIFO is full again: an m0 read must now be held.
      @(negedge clk);
      drive_m(0, 1'b1, 1'b0, 24'h000400, 8'h00);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         chk("t3_full_wait0", m0_waitrequest, 1);
         chk("t3_full_sread", s_read, 0);
      end
      @(negedge clk);
      s_readdatavalid = 1'b1; s_readdata = 8'h32;
      #1;
      chk("t3_pop2_rdv1", m1_readdatavalid, exp_q.pop_front() == 1);
      @(posedge clk);
      #1 s_readdatavalid = 1'b0;
      // m0 read accepted in the same cycle as another return (push + pop).
      @(negedge clk);
      s_readdatavalid = 1'b1; s_readdata = 8'h33;
      #1;
      chk("t3_pp_sread", s_read, 1);
      chk("t3_pp_wait0", m0_waitrequest, 0);
      chk("t3_pp_rdv1", m1_readdatavalid, exp_q.pop_front() == 1);
      exp_q.push_back(0);
      exp_last = 1'b0;
      @(posedge clk);
      #1;
      s_readdatavalid = 1'b0;
      drive_m(0, 1'b0, 1'b0, 24'h0, 8'h0);
      ret(8'h34);
      ret(8'h35);
      ret(8'h36);

      // Test 4: issue order m0,m1,m1,m0 -> returns route in the same order
      issue(0, 1'b1, 24'h000500, 8'h00);
      issue(1, 1'b1, 24'h000501, 8'h00);
      issue(1, 1'b1, 24'h000502, 8'h00);
      issue(0, 1'b1, 24'h000503, 8'h00);
      ret(8'h41);
      ret(8'h42);
      ret(8'h43);
      ret(8'h44);

      // Test 6: controller stalls 10 cycles during a grant
      @(negedge clk);
      s_waitrequest = 1'b1;
      drive_m(0, 1'b0, 1'b1, 24'h000600, 8'h66);
      drive_m(1, 1'b0, 1'b1, 24'h000700, 8'h77);
      g = FIXED ? 1'b0 : ~exp_last;
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         #1;
         chk("t6_addr", s_address, g ? 24'h000700 : 24'h000600);
         chk("t6_swrite", s_write, 1);
         chk("t6_wait_gnt", g ? m1_waitrequest : m0_waitrequest, 1);
         chk("t6_wait_other", g ? m0_waitrequest : m1_waitrequest, 1);
      end
      @(negedge clk);
      s_waitrequest = 1'b0;
      #1;
      chk("t6_release", g ? m1_waitrequest : m0_waitrequest, 0);
      exp_last = g;
      @(posedge clk);
      #1;
      drive_m(0, 1'b0, 1'b0, 24'h0, 8'h0);
      drive_m(1, 1'b0, 1'b0, 24'h0, 8'h0);

      // Test 5: reset discards an outstanding ID -> later return is orphan
      issue(0, 1'b1, 24'h000800, 8'h00);
      @(negedge clk) rst = 1'b1;
      exp_q.delete();
      exp_last = 1'b1;
      @(negedge clk) rst = 1'b0;
      ret(8'h77);
      @(negedge clk);
      #1 chk("t5_sticky", err_orphan, 1);
      @(negedge clk) rst = 1'b1;
      #1 chk("t5_rst_clear", err_orphan, 0);
      @(negedge clk) rst = 1'b0;
      #1 chk("t5_after_rst", err_orphan, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
